hh_neuron_scheduler: RTL and testbench
======================================

# hh_neuron_scheduler

Time-multiplexes one Hodgkin-Huxley update engine across `N_NEURONS` virtual neurons. Holds each neuron's context and stimulus current, sweeps all neurons once per timestep tick over a req/ack handshake to the engine, and queues spike events (neuron IDs) in a small FIFO for the host. It sits between the top-level I/O wrapper and the `hh` datapath, so a single engine instance serves the whole population.

## Interface
Parameters:
- `N_NEURONS`, 4: virtual neurons, 2..16.
- `CTX_W`, 32: opaque per-neuron context width (membrane state plus gating variables).
- `STIM_W`, 8: stimulus current width.
- `CTX_RESET`, 32'h0000_0000: context value loaded at reset.
- `FIFO_DEPTH`, 4: spike FIFO entries, power of two.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick` in 1: timestep strobe, one-cycle pulse.
- `cfg_we` in 1: stimulus write enable.
- `cfg_addr` in clog2(N): neuron index for `cfg_we`.
- `cfg_data` in STIM_W: stimulus value.
- `eng_req` out 1: engine request.
- `eng_id` out clog2(N): neuron being updated.
- `eng_ctx` out CTX_W: context sent to the engine.
- `eng_stim` out STIM_W: stimulus sent to the engine.
- `eng_ack` in 1: engine result valid.
- `eng_ctx_nxt` in CTX_W: updated context.
- `eng_spike` in 1: neuron fired this step.
- `spk_valid` out 1: FIFO non-empty.
- `spk_id` out clog2(N): head neuron ID.
- `spk_pop` in 1: consume head.
- `busy` out 1: sweep in progress.
- `sweep_done` out 1: one-cycle pulse at the end of a sweep.
- `tick_ovf` out 1: sticky; a tick arrived while busy.
- `spk_ovf` out 1: sticky; a spike was dropped because the FIFO was full.

## Operation
- FSM has three states:
  - `IDLE`: waiting for a tick.
  - `REQ`: `eng_req`=1, waiting for ack.
  - `GAP`: `eng_req`=0, index advance.
- `IDLE` → `REQ` on `tick`: idx←0, and `eng_ctx`/`eng_stim` are snapshotted from ctx[0]/stim[0].
- In `REQ`, `eng_req`, `eng_id`, `eng_ctx` and `eng_stim` are registered and held stable until `eng_ack`.
- On an `eng_ack` edge in `REQ`:
  - ctx[idx]←`eng_ctx_nxt`.
  - If `eng_spike`=1, push idx into the FIFO.
  - Go to `GAP`.
- `GAP`:
  - If idx==N_NEURONS-1: go to `IDLE` and pulse `sweep_done`.
  - Otherwise: idx++, snapshot the next ctx/stim, go to `REQ`.
- `eng_ack` outside `REQ` is ignored.
- A `tick` while not `IDLE` is dropped and sets `tick_ovf`. It never restarts or queues a sweep.
- Stimulus writes update stim[cfg_addr] at any time. A write to the neuron currently in `REQ` does not alter the held `eng_stim`; the new value applies from the next sweep.
- `cfg_addr` ≥ N_NEURONS: write ignored.
- FIFO push while full: the ID is dropped and `spk_ovf` is set. Exception: push and pop in the same cycle when full means the pop frees a slot and the push succeeds.
- Pop while empty is ignored.
- Sticky flags clear only on reset.
- Reset, asynchronous at any point including mid-sweep:
  - FSM→`IDLE`, idx=0, ctx[*]=CTX_RESET, stim[*]=0.
  - FIFO empty.
  - All outputs 0; `eng_ctx`=CTX_RESET.

## Timing
- `tick` at edge t → `eng_req`=1 from t+1.
- `eng_ack` at edge a:
  - Context write and FIFO push are visible at a+1.
  - `eng_req`=0 during a+1 (`GAP`).
  - Next request is asserted at a+2.
- Zero-wait engine (ack in the first `REQ` cycle) gives 2 cycles per neuron. A full sweep takes 2·N_NEURONS cycles; `sweep_done` pulses in the `GAP` cycle of the last neuron.
- `busy` = (state≠`IDLE`), registered.
- `spk_valid`/`spk_id` reflect FIFO state after the edge; first-word fall-through.

## Structure
- Package `hh_sched_pkg`: FSM state enum {`IDLE`,`REQ`,`GAP`}, default CTX_W/STIM_W constants, and the index-width helper.
- Sub-module `hh_spike_fifo`: parameterised sync FIFO with the simultaneous push/pop-when-full rule and an overflow output.
- Context and stimulus register arrays stay in the top module.

## Test plan
- Reset, then one tick with a zero-wait engine (ack the same cycle, ctx_nxt=ctx+1): `eng_id` runs 0,1,2,3; `sweep_done` arrives 8 cycles after the tick; every ctx=1.
- Engine with 3-cycle ack latency: `eng_req`/`eng_ctx`/`eng_stim` hold stable for 3 cycles per neuron. A mid-`REQ` `cfg_we` to the active neuron leaves `eng_stim` unchanged, and the next sweep shows the new value.
- Second tick 2 cycles after the first: `tick_ovf`=1 and only one sweep occurs (4 requests).
- All 4 neurons spike for 2 sweeps with no pops: FIFO holds IDs 0,1,2,3 and `spk_ovf`=1. Popping returns 0,1,2,3 in order, then `spk_valid`=0.
- FIFO full with push and pop in the same cycle: occupancy stays 4, no overflow, and the new ID is at the tail.
- `rst_n` low during `REQ` of neuron 2: outputs clear immediately. After release, a tick restarts at `eng_id`=0 with ctx=CTX_RESET.

Source files
------------

// File: rtl/hh_sched_pkg.sv
// rtl/hh_sched_pkg.sv - shared types, default widths and index-width helper for the HH neuron scheduler
package hh_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    localparam int CTX_W_DEF  = 32;
    localparam int STIM_W_DEF = 8;

    // Neuron index width; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hh_spike_fifo.sv
// rtl/hh_spike_fifo.sv - first-word fall-through spike ID FIFO with sticky drop flag
module hh_spike_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic         ovf
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    assign valid = (count != '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
            if (push && !do_push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hh_neuron_scheduler.sv
// rtl/hh_neuron_scheduler.sv - sweeps N virtual neurons through one HH engine per timestep tick
module hh_neuron_scheduler
    import hh_sched_pkg::*;
#(
    parameter int               N_NEURONS  = 4,
    parameter int               CTX_W      = CTX_W_DEF,
    parameter int               STIM_W     = STIM_W_DEF,
    parameter logic [CTX_W-1:0] CTX_RESET  = '0,
    parameter int               FIFO_DEPTH = 4,
    localparam int              IW         = idx_w(N_NEURONS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_addr,
    input  logic [STIM_W-1:0] cfg_data,
    output logic              eng_req,
    output logic [IW-1:0]     eng_id,
    output logic [CTX_W-1:0]  eng_ctx,
    output logic [STIM_W-1:0] eng_stim,
    input  logic              eng_ack,
    input  logic [CTX_W-1:0]  eng_ctx_nxt,
    input  logic              eng_spike,
    output logic              spk_valid,
    output logic [IW-1:0]     spk_id,
    input  logic              spk_pop,
    output logic              busy,
    output logic              sweep_done,
    output logic              tick_ovf,
    output logic              spk_ovf
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_inc;
    logic [CTX_W-1:0]  ctx  [N_NEURONS];
    logic [STIM_W-1:0] stim [N_NEURONS];
    logic              start;
    logic              advance;
    logic              take_ack;
    logic              last;

    assign last       = (idx == LAST_IDX);
    assign idx_inc    = idx + 1'b1;
    assign eng_id     = idx;
    assign sweep_done = (state == GAP) && last;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        advance   = 1'b0;
        take_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    start     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (eng_ack) begin
                    take_ack  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (last) begin
                    state_nxt = IDLE;
                end else begin
                    advance   = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Engine-facing outputs are snapshots, so stimulus writes mid-request never disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            eng_req  <= 1'b0;
            busy     <= 1'b0;
            eng_ctx  <= CTX_RESET;
            eng_stim <= '0;
            tick_ovf <= 1'b0;
        end else begin
            state   <= state_nxt;
            eng_req <= (state_nxt == REQ);
            busy    <= (state_nxt != IDLE);
            if (tick && (state != IDLE)) tick_ovf <= 1'b1;
            if (start) begin
                idx      <= '0;
                eng_ctx  <= ctx[0];
                eng_stim <= stim[0];
            end else if (advance) begin
                idx      <= idx_inc;
                eng_ctx  <= ctx[idx_inc];
                eng_stim <= stim[idx_inc];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                ctx[i]  <= CTX_RESET;
                stim[i] <= '0;
            end
        end else begin
            if (take_ack) ctx[idx] <= eng_ctx_nxt;
            if (cfg_we && (int'(cfg_addr) < N_NEURONS)) stim[cfg_addr] <= cfg_data;
        end
    end

    hh_spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IW)
    ) u_spike_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (take_ack && eng_spike),
        .push_data (idx),
        .pop       (spk_pop),
        .valid     (spk_valid),
        .head      (spk_id),
        .ovf       (spk_ovf)
    );

endmodule

// File: tb/tb_hh_neuron_scheduler.sv
// tb/tb_hh_neuron_scheduler.sv - self-checking bench for hh_neuron_scheduler
module tb_hh_neuron_scheduler;

    localparam int          N     = 4;
    localparam logic [31:0] CTX_R = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        eng_req;
    logic [1:0]  eng_id;
    logic [31:0] eng_ctx;
    logic [7:0]  eng_stim;
    logic        eng_ack;
    logic [31:0] eng_ctx_nxt;
    logic        eng_spike;
    logic        spk_valid;
    logic [1:0]  spk_id;
    logic        spk_pop;
    logic        pop_main;
    logic        pop_eng;
    logic        busy;
    logic        sweep_done;
    logic        tick_ovf;
    logic        spk_ovf;

    always #5 clk = ~clk;
    assign spk_pop = pop_main | pop_eng;

    hh_neuron_scheduler #(
        .N_NEURONS  (N),
        .CTX_W      (32),
        .STIM_W     (8),
        .CTX_RESET  (CTX_R),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .eng_req     (eng_req),
        .eng_id      (eng_id),
        .eng_ctx     (eng_ctx),
        .eng_stim    (eng_stim),
        .eng_ack     (eng_ack),
        .eng_ctx_nxt (eng_ctx_nxt),
        .eng_spike   (eng_spike),
        .spk_valid   (spk_valid),
        .spk_id      (spk_id),
        .spk_pop     (spk_pop),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .tick_ovf    (tick_ovf),
        .spk_ovf     (spk_ovf)
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] ctx;
        logic [7:0]  stim;
    } req_t;

    typedef struct {
        int         lat;
        logic [3:0] mask;
        int         xtick;
        int         cfg_k;
        logic [1:0] cfg_a;
        logic [7:0] cfg_d;
        bit         pop_ack;
        bit         drain;
        int         cyc;
        int         nreq;
        int         ndone;
        bit         tovf;
        bit         sovf;
    } vec_t;

    req_t        req_q[$];
    logic [1:0]  spk_q[$];
    logic [31:0] m_ctx  [N];
    logic [7:0]  m_stim [N];
    vec_t        vecs [8];

    int         total = 0;
    int         bad   = 0;
    int         n_req = 0;
    int         lat   = 0;
    logic [3:0] spike_mask = 4'b0000;
    bit         pop_on_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ctx[i]  = CTX_R;
            m_stim[i] = 8'h00;
        end
        req_q.delete();
        spk_q.delete();
    endtask

    task automatic push_expect();
        req_t r;
        for (int i = 0; i < N; i++) begin
            r.id   = 2'(i);
            r.ctx  = m_ctx[i];
            r.stim = m_stim[i];
            req_q.push_back(r);
        end
    endtask

    // Engine model: acks after lat extra REQ cycles, returns ctx+1, spikes per spike_mask.
    initial begin : engine
        req_t cur;
        bit   in_req;
        int   wcnt;
        eng_ack     = 1'b0;
        eng_ctx_nxt = 32'd0;
        eng_spike   = 1'b0;
        pop_eng     = 1'b0;
        in_req      = 1'b0;
        wcnt        = 0;
        cur.id      = 2'd0;
        cur.ctx     = 32'd0;
        cur.stim    = 8'd0;
        forever begin
            @(negedge clk);
            eng_ack   = 1'b0;
            eng_spike = 1'b0;
            pop_eng   = 1'b0;
            if (!rst_n || !eng_req) begin
                in_req = 1'b0;
            end else begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wcnt   = 0;
                    n_req++;
                    if (req_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
                    else cur = req_q.pop_front();
                end
                check("eng_id", 32'(eng_id), 32'(cur.id));
                check("eng_ctx", eng_ctx, cur.ctx);
                check("eng_stim", 32'(eng_stim), 32'(cur.stim));
                if (wcnt >= lat) begin
                    eng_ack          = 1'b1;
                    eng_ctx_nxt      = cur.ctx + 32'd1;
                    m_ctx[cur.id]    = cur.ctx + 32'd1;
                    eng_spike        = spike_mask[cur.id];
                    in_req           = 1'b0;
                    if (eng_spike) begin
                        if (pop_on_ack && spk_q.size() > 0) begin
                            pop_eng = 1'b1;
                            check("spk_valid_at_pop", 32'(spk_valid), 32'd1);
                            check("spk_head_at_pop", 32'(spk_id), 32'(spk_q.pop_front()));
                        end
                        if (spk_q.size() < 4) spk_q.push_back(cur.id);
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic drain();
        logic [31:0] e;
        int          got;
        got = 0;
        while (spk_valid && got < 8) begin
            if (spk_q.size() > 0) e = 32'(spk_q.pop_front());
            else e = 32'hDEAD;
            check("spk_id", 32'(spk_id), e);
            pop_main = 1'b1;
            @(negedge clk);
            pop_main = 1'b0;
            got++;
        end
        check("spk_valid_after_drain", 32'(spk_valid), 32'd0);
        check("model_fifo_left", 32'(spk_q.size()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        int ndone;
        int req0;
        lat        = v.lat;
        spike_mask = v.mask;
        pop_on_ack = v.pop_ack;
        push_expect();
        req0  = n_req;
        cyc   = 0;
        ndone = 0;
        tick  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            tick     = (k == v.xtick);
            cfg_we   = (k == v.cfg_k);
            cfg_addr = v.cfg_a;
            cfg_data = v.cfg_d;
            if (k == v.cfg_k) m_stim[v.cfg_a] = v.cfg_d;
            if (sweep_done) begin
                ndone++;
                if (cyc == 0) cyc = k;
            end
        end
        pop_on_ack = 1'b0;
        check("sweep_cycles", 32'(cyc), 32'(v.cyc));
        check("request_count", 32'(n_req - req0), 32'(v.nreq));
        check("sweep_done_count", 32'(ndone), 32'(v.ndone));
        check("busy_after", 32'(busy), 32'd0);
        check("tick_ovf", 32'(tick_ovf), 32'(v.tovf));
        check("spk_ovf", 32'(spk_ovf), 32'(v.sovf));
        check("model_req_left", 32'(req_q.size()), 32'd0);
        if (v.drain) drain();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_eng_req"}, 32'(eng_req), 32'd0);
        check({tag, "_eng_id"}, 32'(eng_id), 32'd0);
        check({tag, "_eng_ctx"}, eng_ctx, CTX_R);
        check({tag, "_eng_stim"}, 32'(eng_stim), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
        check({tag, "_spk_valid"}, 32'(spk_valid), 32'd0);
        check({tag, "_tick_ovf"}, 32'(tick_ovf), 32'd0);
        check({tag, "_spk_ovf"}, 32'(spk_ovf), 32'd0);
    endtask

    initial begin : main
        vec_t post;
        bit   found;
        rst_n    = 1'b0;
        tick     = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = 8'd0;
        pop_main = 1'b0;
        model_reset();

        //        lat  mask     xt cfgk cfga   cfgd    pop   drain cyc nreq done tovf  sovf
        vecs[0] = '{0, 4'b0000, 0, 0, 2'd0, 8'h00, 1'b0, 1'b1, 8,  4, 1, 1'b0, 1'b0};
        vecs[1] = '{2, 4'b0000, 0, 6, 2'd1, 8'hAB, 1'b0, 1'b1, 16, 4, 1, 1'b0, 1'b0};
        vecs[2] = '{1, 4'b0101, 0, 0, 2'd0, 8'h00, 1'b0, 1'b1, 12, 4, 1, 1'b0, 1'b0};
        vecs[3] = '{0, 4'b0000, 2, 0, 2'd0, 8'h00, 1'b0, 1'b1, 8,  4, 1, 1'b1, 1'b0};
        vecs[4] = '{0, 4'b1111, 0, 0, 2'd0, 8'h00, 1'b0, 1'b0, 8,  4, 1, 1'b1, 1'b0};
        vecs[5] = '{0, 4'b0100, 0, 0, 2'd0, 8'h00, 1'b1, 1'b1, 8,  4, 1, 1'b1, 1'b0};
        vecs[6] = '{0, 4'b1111, 0, 0, 2'd0, 8'h00, 1'b0, 1'b0, 8,  4, 1, 1'b1, 1'b0};
        vecs[7] = '{0, 4'b1111, 0, 0, 2'd0, 8'h00, 1'b0, 1'b1, 8,  4, 1, 1'b1, 1'b1};
        post    = '{0, 4'b0000, 0, 0, 2'd0, 8'h00, 1'b0, 1'b1, 8,  4, 1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_cleared("post_reset");

        for (int i = 0; i < N; i++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 2'(i);
            cfg_data  = 8'h10 + 8'(i);
            m_stim[i] = cfg_data;
            @(negedge clk);
        end
        cfg_we = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of neuron 2's request.
        lat        = 5;
        spike_mask = 4'b0000;
        push_expect();
        tick = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (eng_req && eng_id == 2'd2) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_neuron2", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_cleared("mid_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(post);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
